// File: rtl/matvec_stream_if.sv
// matvec_stream_if: weight matrix, input beat stream and result stream of matvec_stream
// Ports: k (R x C signed weights), s_valid/s_ready/s_data (P lanes of x per beat),
// m_valid/m_ready/y (R-element signed result). slave = multiplier side, master = driver side.
interface matvec_stream_if #(
  parameter int R = 8,
  parameter int C = 16,
  parameter int P = 4,
  parameter int W_X = 8,
  parameter int W_K = 8
);
  localparam int W_Y = W_X + W_K + $clog2(C);
  logic signed [R-1:0][C-1:0][W_K-1:0] k;
  logic s_valid;
  logic s_ready;
  logic signed [P-1:0][W_X-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic signed [R-1:0][W_Y-1:0] y;
  modport slave(input k, s_valid, s_data, m_ready, output s_ready, m_valid, y);
  modport master(output k, s_valid, s_data, m_ready, input s_ready, m_valid, y);
endinterface

// File: rtl/matvec_stream.sv
// matvec_stream: folded streaming signed matrix-vector multiplier y = K*x
// Ports: clk; rst (sync, active-high); bus (slave) carries k, the s_* beat stream
// (lane p of beat b is x[b*P+p]) and the m_* result stream (R elements of y).
module matvec_stream #(
  parameter int R = 8,
  parameter int C = 16,
  parameter int P = 4,
  parameter int W_X = 8,
  parameter int W_K = 8
) (
  input logic clk,
  input logic rst,
  matvec_stream_if.slave bus
);
  localparam int BEATS = C / P;
  localparam int TD = $clog2(P);
  localparam int W_Y = W_X + W_K + $clog2(C);
  localparam int W_M = W_X + W_K;
  localparam int W_C = $clog2(C);
  localparam int W_B = BEATS > 1 ? $clog2(BEATS) : 1;
  logic w_adv;
  logic w_last;
  logic [W_B-1:0] r_b;
  logic signed [W_M-1:0] r_prod [R][P];
  logic r_m_v;
  logic r_m_l;
  logic signed [W_Y-1:0] w_lv [TD][R][P];
  logic signed [W_Y-1:0] r_t [TD][R][P/2];
  logic [TD-1:0] r_tv;
  logic [TD-1:0] r_tl;
  logic signed [W_Y-1:0] r_acc [R];
  logic signed [R-1:0][W_Y-1:0] r_y;
  logic r_mv;
  // the whole pipeline freezes only while a result is stuck waiting for m_ready
  assign w_adv = !(r_mv && !bus.m_ready);
  assign w_last = r_b == W_B'(BEATS - 1);
  assign bus.s_ready = w_adv;
  assign bus.m_valid = r_mv;
  assign bus.y = r_y;
  // tree level inputs: level 0 is the sign-extended products, level l+1 the registered sums of level l
  always_comb begin
    w_lv = '{default: '0};
    for (int r = 0; r < R; r++) begin
      for (int p = 0; p < P; p++) w_lv[0][r][p] = W_Y'(r_prod[r][p]);
      for (int l = 0; l < TD - 1; l++)
        for (int j = 0; j < P / 2; j++) w_lv[l+1][r][j] = r_t[l][r][j];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b <= '0;
      r_m_v <= 1'b0;
      r_m_l <= 1'b0;
      r_tv <= '0;
      r_tl <= '0;
      r_mv <= 1'b0;
      r_y <= '0;
      for (int r = 0; r < R; r++) r_acc[r] <= '0;
    end else if (w_adv) begin
      if (bus.s_valid) r_b <= w_last ? '0 : r_b + W_B'(1);
      r_m_v <= bus.s_valid;
      r_m_l <= bus.s_valid && w_last;
      r_tv[0] <= r_m_v;
      r_tl[0] <= r_m_l;
      for (int l = 1; l < TD; l++) begin
        r_tv[l] <= r_tv[l-1];
        r_tl[l] <= r_tl[l-1];
      end
      // a result loading now keeps m_valid high; otherwise an accepted result clears it
      r_mv <= r_tv[TD-1] && r_tl[TD-1];
      for (int r = 0; r < R; r++) begin
        for (int p = 0; p < P; p++)
          r_prod[r][p] <= W_M'($signed(bus.k[r][W_C'(int'(r_b) * P + p)])) * W_M'($signed(bus.s_data[p]));
        for (int l = 0; l < TD; l++)
          for (int j = 0; j < P / 2; j++) r_t[l][r][j] <= w_lv[l][r][2*j] + w_lv[l][r][2*j+1];
        if (r_tv[TD-1]) begin
          if (r_tl[TD-1]) begin
            r_y[r] <= r_acc[r] + r_t[TD-1][r][0];
            r_acc[r] <= '0;
          end else begin
            r_acc[r] <= r_acc[r] + r_t[TD-1][r][0];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_matvec_stream.sv
// tb_matvec_stream: directed self-checking bench for matvec_stream at R=2, C=4, P=2
module tb_matvec_stream;
  localparam int R = 2;
  localparam int C = 4;
  localparam int P = 2;
  localparam int W_X = 8;
  localparam int W_K = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int idx, nres, st;
  logic acc, cons;
  int bx [6][2] = '{'{1, 2}, '{3, 4}, '{-1, 0}, '{2, -3}, '{10, 10}, '{10, 10}};
  int ey0 [3] = '{30, -7, 100};
  int ey1 [3] = '{-18, 33, -20};
  always #5 clk = ~clk;
  matvec_stream_if #(.R(R), .C(C), .P(P), .W_X(W_X), .W_K(W_K)) bus();
  matvec_stream #(.R(R), .C(C), .P(P), .W_X(W_X), .W_K(W_K)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_y(input string tag, input int e0, input int e1);
    chk({tag, "_y0"}, $signed(bus.y[0]), e0);
    chk({tag, "_y1"}, $signed(bus.y[1]), e1);
  endtask
  task automatic set_row(input int r, input int v0, input int v1, input int v2, input int v3);
    bus.k[r][0] = 8'(v0);
    bus.k[r][1] = 8'(v1);
    bus.k[r][2] = 8'(v2);
    bus.k[r][3] = 8'(v3);
  endtask
  task automatic beat(input int a, input int b);
    bus.s_valid = 1'b1;
    bus.s_data[0] = 8'(a);
    bus.s_data[1] = 8'(b);
  endtask
  task automatic idle();
    bus.s_valid = 1'b0;
  endtask
  task automatic send_vec(input int a0, input int a1, input int a2, input int a3);
    beat(a0, a1);
    tick();
    beat(a2, a3);
    tick();
    idle();
  endtask
  task automatic wait_mv(input string tag, input int max);
    for (int i = 0; i < max && bus.m_valid !== 1'b1; i++) tick();
    chk({tag, "_mv"}, bus.m_valid, 1);
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b1;
    bus.k = '0;
    repeat (2) tick();
    chk("rst_mv", bus.m_valid, 0);
    chk_y("rst", 0, 0);
    rst = 1'b0;
    tick();
    chk("rst_sready", bus.s_ready, 1);
    // basic vector and latency: result visible after the third edge counting the last beat's edge
    set_row(0, 1, 2, 3, 4);
    set_row(1, -1, -1, -1, -1);
    beat(1, 1);
    tick();
    beat(1, 1);
    tick();
    idle();
    chk("lat_e1", bus.m_valid, 0);
    tick();
    chk("lat_e2", bus.m_valid, 0);
    tick();
    chk("lat_e3", bus.m_valid, 1);
    chk_y("basic", 10, -4);
    tick();
    chk("basic_pulse", bus.m_valid, 0);
    // extremes
    for (int r = 0; r < R; r++) set_row(r, -128, -128, -128, -128);
    send_vec(-128, -128, -128, -128);
    wait_mv("ext_neg", 6);
    chk_y("ext_neg", 65536, 65536);
    tick();
    for (int r = 0; r < R; r++) set_row(r, 127, 127, 127, 127);
    send_vec(-128, -128, -128, -128);
    wait_mv("ext_mix", 6);
    chk_y("ext_mix", -65024, -65024);
    tick();
    // back-to-back vectors, no stalls
    set_row(0, 1, 2, 3, 4);
    set_row(1, 5, -6, 7, -8);
    for (int e = 1; e <= 8; e++) begin
      if (e <= 6) begin
        beat(bx[e-1][0], bx[e-1][1]);
        chk("b2b_sready", bus.s_ready, 1);
      end else idle();
      tick();
      chk("b2b_mv", bus.m_valid, (e >= 4 && e % 2 == 0));
      if (e >= 4 && e % 2 == 0) chk_y("b2b", ey0[e/2-2], ey1[e/2-2]);
    end
    tick();
    // backpressure: hold m_ready low for the first 5 cycles of the first result
    idx = 0;
    nres = 0;
    st = 0;
    for (int t = 0; t < 60 && !(nres == 3 && idx == 6); t++) begin
      bus.m_ready = (st >= 5);
      if (bus.m_valid && !bus.m_ready) st++;
      if (idx < 6) beat(bx[idx][0], bx[idx][1]);
      else idle();
      #1;
      if (bus.m_valid) begin
        if (nres < 3) chk_y("bp", ey0[nres], ey1[nres]);
        else chk("bp_extra", bus.m_valid, 0);
        if (!bus.m_ready) chk("bp_sready", bus.s_ready, 0);
      end
      acc = bus.s_valid && bus.s_ready;
      cons = bus.m_valid && bus.m_ready;
      tick();
      idx += int'(acc);
      nres += int'(cons);
    end
    chk("bp_nres", nres, 3);
    chk("bp_idx", idx, 6);
    chk("bp_stall", st, 5);
    bus.m_ready = 1'b1;
    idle();
    tick();
    // bubbles between beats
    beat(1, 2);
    tick();
    idle();
    repeat (3) tick();
    chk("bub_quiet", bus.m_valid, 0);
    beat(3, 4);
    tick();
    idle();
    wait_mv("bub", 6);
    chk_y("bub", 30, -18);
    tick();
    // reset mid-vector
    beat(9, 9);
    tick();
    idle();
    rst = 1'b1;
    tick();
    chk("mid_rst_mv", bus.m_valid, 0);
    chk_y("mid_rst", 0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_mv", bus.m_valid, 0);
    chk_y("post_rst", 0, 0);
    send_vec(-1, 0, 2, -3);
    wait_mv("fresh", 6);
    chk_y("fresh", -7, 33);
    tick();
    chk("fresh_pulse", bus.m_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
